// File: rtl/io_int_ctrl.sv
// io_int_ctrl: memory-mapped external-interrupt controller on the IO bus.
// Latches NSRC sources as pending (edge or level), masks them, picks the
// lowest-index request and runs a claim/complete handshake with the CSR unit
// so that only one source is in service at a time.
module io_int_ctrl #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned IDW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dma_io_we,
    input  logic [13:0]     dma_io_wadr,
    input  logic [31:0]     dma_io_wdata,
    input  logic [13:0]     dma_io_radr,
    input  logic            dma_io_radr_en,
    input  logic [31:0]     dma_io_rdata_in,
    output logic [31:0]     dma_io_rdata,
    input  logic [NSRC-1:0] int_src,
    input  logic            csr_meie,
    output logic            ext_int_req,
    output logic            interrupt_clear
);

    localparam logic [13:0] ADR_PEND  = 14'h3E88;
    localparam logic [13:0] ADR_ENBL  = 14'h3E89;
    localparam logic [13:0] ADR_CLAIM = 14'h3E8A;
    localparam logic [13:0] ADR_TYPE  = 14'h3E8B;

    typedef enum logic {
        ST_IDLE,
        ST_SERVICE
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] type_q, type_d;
    logic [NSRC-1:0] src_q;
    logic [IDW-1:0]  svc_id_q, svc_id_d;
    logic            ext_int_req_q, ext_int_req_d;
    logic            int_clr_q, int_clr_d;
    logic            rd_hit_q, rd_hit_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            wr_pend, wr_enbl, wr_claim, wr_type;
    logic            rd_claim;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] win_oh;
    logic [IDW-1:0]  winner;
    logic            any;
    logic            claim_take;
    logic [31:0]     claim_val;
    logic [31:0]     rd_val;
    logic            unused_wdata;

    assign wr_pend  = dma_io_we && (dma_io_wadr == ADR_PEND);
    assign wr_enbl  = dma_io_we && (dma_io_wadr == ADR_ENBL);
    assign wr_claim = dma_io_we && (dma_io_wadr == ADR_CLAIM);
    assign wr_type  = dma_io_we && (dma_io_wadr == ADR_TYPE);
    assign rd_claim = dma_io_radr_en && (dma_io_radr == ADR_CLAIM);

    assign cand         = pending_q & enable_q;
    assign unused_wdata = ^dma_io_wdata;

    // Fixed-priority arbitration: lowest set index of pending & enable wins.
    always_comb begin
        winner = '0;
        win_oh = '0;
        any    = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (cand[i] && !any) begin
                any       = 1'b1;
                winner    = IDW'(i);
                win_oh[i] = 1'b1;
            end
        end
    end

    // Claim/complete sequencer: next state, request line and clear pulse.
    always_comb begin
        state_d       = state_q;
        svc_id_d      = svc_id_q;
        ext_int_req_d = 1'b0;
        int_clr_d     = 1'b0;
        claim_take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_claim && any) begin
                    claim_take = 1'b1;
                    svc_id_d   = winner;
                    state_d    = ST_SERVICE;
                end else begin
                    ext_int_req_d = any & csr_meie;
                end
            end
            ST_SERVICE: begin
                if (wr_claim && (dma_io_wdata[IDW-1:0] == svc_id_q)) begin
                    state_d   = ST_IDLE;
                    int_clr_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending capture: edge sources set on a rise (beating W1C and claim
    // clears), level sources simply track int_src.
    always_comb begin
        logic [NSRC-1:0] edge_next;
        logic [NSRC-1:0] w1c_mask;
        logic [NSRC-1:0] claim_mask;
        w1c_mask   = wr_pend ? dma_io_wdata[NSRC-1:0] : '0;
        claim_mask = claim_take ? win_oh : '0;
        edge_next  = (pending_q & ~w1c_mask & ~claim_mask) | (int_src & ~src_q);
        pending_d  = (type_q & edge_next) | (~type_q & int_src);
    end

    // Enable and type configuration writes.
    always_comb begin
        enable_d = enable_q;
        type_d   = type_q;
        if (wr_enbl) begin
            enable_d = dma_io_wdata[NSRC-1:0];
        end
        if (wr_type) begin
            type_d = dma_io_wdata[NSRC-1:0];
        end
    end

    // Claim read word: valid bit plus the ID in service or the current winner.
    always_comb begin
        claim_val = '0;
        if (state_q == ST_SERVICE) begin
            claim_val[31]      = 1'b1;
            claim_val[IDW-1:0] = svc_id_q;
        end else if (any) begin
            claim_val[31]      = 1'b1;
            claim_val[IDW-1:0] = winner;
        end
    end

    // Read decode; data is captured only on an address hit.
    always_comb begin
        rd_val   = '0;
        rd_hit_d = 1'b0;
        if (dma_io_radr_en) begin
            case (dma_io_radr)
                ADR_PEND: begin
                    rd_val[NSRC-1:0] = pending_q;
                    rd_hit_d         = 1'b1;
                end
                ADR_ENBL: begin
                    rd_val[NSRC-1:0] = enable_q;
                    rd_hit_d         = 1'b1;
                end
                ADR_CLAIM: begin
                    rd_val   = claim_val;
                    rd_hit_d = 1'b1;
                end
                ADR_TYPE: begin
                    rd_val[NSRC-1:0] = type_q;
                    rd_hit_d         = 1'b1;
                end
                default: ;
            endcase
        end
        rdata_d = rd_hit_d ? rd_val : rdata_q;
    end

    // State, configuration, capture and read-path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            enable_q      <= '0;
            type_q        <= '0;
            src_q         <= '0;
            svc_id_q      <= '0;
            ext_int_req_q <= 1'b0;
            int_clr_q     <= 1'b0;
            rd_hit_q      <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            enable_q      <= enable_d;
            type_q        <= type_d;
            src_q         <= int_src;
            svc_id_q      <= svc_id_d;
            ext_int_req_q <= ext_int_req_d;
            int_clr_q     <= int_clr_d;
            rd_hit_q      <= rd_hit_d;
            rdata_q       <= rdata_d;
        end
    end

    assign dma_io_rdata    = rd_hit_q ? rdata_q : dma_io_rdata_in;
    assign ext_int_req     = ext_int_req_q;
    assign interrupt_clear = int_clr_q;

endmodule

// File: tb/tb_io_int_ctrl.sv
// Testbench for io_int_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a per-source behavioural model.
module tb_io_int_ctrl;

    localparam int NSRC = 4;
    localparam int IDW  = 4;

    localparam logic [13:0] ADR_PEND  = 14'h3E88;
    localparam logic [13:0] ADR_ENBL  = 14'h3E89;
    localparam logic [13:0] ADR_CLAIM = 14'h3E8A;
    localparam logic [13:0] ADR_TYPE  = 14'h3E8B;

    logic            clk;
    logic            rst_n;
    logic            dma_io_we;
    logic [13:0]     dma_io_wadr;
    logic [31:0]     dma_io_wdata;
    logic [13:0]     dma_io_radr;
    logic            dma_io_radr_en;
    logic [31:0]     dma_io_rdata_in;
    logic [31:0]     dma_io_rdata;
    logic [NSRC-1:0] int_src;
    logic            csr_meie;
    logic            ext_int_req;
    logic            interrupt_clear;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [NSRC-1:0] m_pend, m_en, m_type, m_src;
    logic            m_svc;
    logic [IDW-1:0]  m_id;
    logic            m_req, m_clr, m_hit;
    logic [31:0]     m_rdata;

    io_int_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dma_io_we       (dma_io_we),
        .dma_io_wadr     (dma_io_wadr),
        .dma_io_wdata    (dma_io_wdata),
        .dma_io_radr     (dma_io_radr),
        .dma_io_radr_en  (dma_io_radr_en),
        .dma_io_rdata_in (dma_io_rdata_in),
        .dma_io_rdata    (dma_io_rdata),
        .int_src         (int_src),
        .csr_meie        (csr_meie),
        .ext_int_req     (ext_int_req),
        .interrupt_clear (interrupt_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_type = '0; m_src = '0;
        m_svc = 1'b0; m_id = '0;
        m_req = 1'b0; m_clr = 1'b0; m_hit = 1'b0; m_rdata = '0;
    endtask

    // One clock: predict from current inputs, step the DUT, compare outputs.
    task automatic cyc();
        int              win;
        logic            take, done, hit, nreq;
        logic [31:0]     claimv, rv;
        logic [NSRC-1:0] np, ne, nt, src_now;
        logic            nsvc;
        logic [IDW-1:0]  nid;

        win = -1;
        for (int i = 0; i < NSRC; i++)
            if (win < 0 && m_pend[i] && m_en[i]) win = i;

        take = dma_io_radr_en && dma_io_radr == ADR_CLAIM && !m_svc && win >= 0;
        done = dma_io_we && dma_io_wadr == ADR_CLAIM && m_svc && dma_io_wdata[IDW-1:0] == m_id;

        if (m_svc)        claimv = 32'h8000_0000 | 32'(m_id);
        else if (win >= 0) claimv = 32'h8000_0000 | 32'(win);
        else               claimv = 32'h0;

        hit = dma_io_radr_en;
        rv  = 32'h0;
        if (dma_io_radr_en) begin
            case (dma_io_radr)
                ADR_PEND:  rv = 32'(m_pend);
                ADR_ENBL:  rv = 32'(m_en);
                ADR_CLAIM: rv = claimv;
                ADR_TYPE:  rv = 32'(m_type);
                default:   hit = 1'b0;
            endcase
        end

        for (int i = 0; i < NSRC; i++) begin
            if (m_type[i]) begin
                if (int_src[i] && !m_src[i])
                    np[i] = 1'b1;
                else if ((dma_io_we && dma_io_wadr == ADR_PEND && dma_io_wdata[i]) || (take && win == i))
                    np[i] = 1'b0;
                else
                    np[i] = m_pend[i];
            end else begin
                np[i] = int_src[i];
            end
        end

        ne = (dma_io_we && dma_io_wadr == ADR_ENBL) ? dma_io_wdata[NSRC-1:0] : m_en;
        nt = (dma_io_we && dma_io_wadr == ADR_TYPE) ? dma_io_wdata[NSRC-1:0] : m_type;
        nreq = !m_svc && !take && win >= 0 && csr_meie;
        nsvc = take ? 1'b1 : (done ? 1'b0 : m_svc);
        nid  = take ? IDW'(win) : m_id;
        src_now = int_src;

        @(posedge clk);
        #1;
        m_pend = np; m_en = ne; m_type = nt; m_src = src_now;
        m_svc = nsvc; m_id = nid; m_req = nreq; m_clr = done;
        m_hit = hit;
        if (hit) m_rdata = rv;

        check("ext_int_req", 32'(ext_int_req), 32'(m_req));
        check("interrupt_clear", 32'(interrupt_clear), 32'(m_clr));
        check("rdata", dma_io_rdata, m_hit ? m_rdata : dma_io_rdata_in);
    endtask

    task automatic wr(input logic [13:0] adr, input logic [31:0] data);
        dma_io_we = 1'b1; dma_io_wadr = adr; dma_io_wdata = data;
        cyc();
        dma_io_we = 1'b0;
    endtask

    task automatic rd(input logic [13:0] adr, output logic [31:0] data);
        dma_io_radr_en = 1'b1; dma_io_radr = adr;
        cyc();
        dma_io_radr_en = 1'b0;
        data = dma_io_rdata;
    endtask

    initial begin
        logic [31:0] d;
        int          op;

        rst_n = 1'b0; dma_io_we = 1'b0; dma_io_wadr = '0; dma_io_wdata = '0;
        dma_io_radr = '0; dma_io_radr_en = 1'b0; dma_io_rdata_in = 32'hDEAD_BEEF;
        int_src = '0; csr_meie = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(ext_int_req), 32'h0);
        check("rst_clr", 32'(interrupt_clear), 32'h0);
        check("rst_rdata_pass", dma_io_rdata, 32'hDEAD_BEEF);
        rst_n = 1'b1;

        // 1: edge source 0 raises a request
        wr(ADR_ENBL, 32'h1);
        wr(ADR_TYPE, 32'h1);
        csr_meie = 1'b1;
        int_src = 4'b0001;
        cyc();
        int_src = 4'b0000;
        check("t1_req_early", 32'(ext_int_req), 32'h0);
        cyc();
        check("t1_req", 32'(ext_int_req), 32'h1);
        rd(ADR_PEND, d);
        check("t1_pend", d, 32'h1);

        // 2: level sources 1 and 3, claim and complete
        wr(ADR_PEND, 32'h1);
        wr(ADR_ENBL, 32'hA);
        int_src = 4'b1010;
        cyc();
        cyc();
        check("t2_req", 32'(ext_int_req), 32'h1);
        rd(ADR_CLAIM, d);
        check("t2_claim", d, 32'h8000_0001);
        check("t2_req_drop", 32'(ext_int_req), 32'h0);
        wr(ADR_CLAIM, 32'h2);
        check("t3_bad_id", 32'(interrupt_clear), 32'h0);
        int_src = 4'b1000;
        cyc();
        wr(ADR_CLAIM, 32'h1);
        check("t2_clr", 32'(interrupt_clear), 32'h1);
        cyc();
        check("t2_clr_once", 32'(interrupt_clear), 32'h0);
        check("t2_req_src3", 32'(ext_int_req), 32'h1);
        rd(ADR_CLAIM, d);
        check("t2_claim3", d, 32'h8000_0003);
        wr(ADR_CLAIM, 32'h3);
        int_src = 4'b0000;
        cyc();
        cyc();

        // 3: claim with nothing pending, complete while idle
        rd(ADR_CLAIM, d);
        check("t3_claim_empty", d, 32'h0);
        wr(ADR_CLAIM, 32'h0);
        check("t3_idle_complete", 32'(interrupt_clear), 32'h0);

        // 4: edge set beats W1C in the same cycle
        wr(ADR_ENBL, 32'h0);
        wr(ADR_TYPE, 32'h4);
        int_src = 4'b0100;
        wr(ADR_PEND, 32'h4);
        rd(ADR_PEND, d);
        check("t4_set_wins", d, 32'h4);
        wr(ADR_PEND, 32'h4);
        rd(ADR_PEND, d);
        check("t4_w1c", d, 32'h0);

        // 5: csr_meie gates the request
        csr_meie = 1'b0;
        wr(ADR_ENBL, 32'h4);
        int_src = 4'b0000;
        cyc();
        int_src = 4'b0100;
        cyc();
        cyc();
        cyc();
        check("t5_meie_off", 32'(ext_int_req), 32'h0);
        rd(ADR_PEND, d);
        check("t5_pend_accum", d, 32'h4);
        csr_meie = 1'b1;
        cyc();
        check("t5_meie_on", 32'(ext_int_req), 32'h1);

        // 6: reset during service
        rd(ADR_CLAIM, d);
        check("t6_claim", d, 32'h8000_0002);
        int_src = 4'b0000;
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", 32'(ext_int_req), 32'h0);
        check("t6_rst_clr", 32'(interrupt_clear), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("t6_rst_clr_hold", 32'(interrupt_clear), 32'h0);
        rst_n = 1'b1;
        model_reset();
        rd(ADR_PEND, d);  check("t6_pend", d, 32'h0);
        rd(ADR_ENBL, d);  check("t6_enbl", d, 32'h0);
        rd(ADR_TYPE, d);  check("t6_type", d, 32'h0);
        rd(ADR_CLAIM, d); check("t6_claim_idle", d, 32'h0);
        rd(14'h0123, d);  check("t6_unmapped", d, 32'hDEAD_BEEF);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0)
                int_src = int_src ^ NSRC'(1 << $urandom_range(0, NSRC - 1));
            csr_meie = ($urandom_range(0, 7) != 0);
            dma_io_rdata_in = $urandom;
            op = $urandom_range(0, 9);
            dma_io_we = (op < 4);
            dma_io_wadr = (op == 0) ? 14'($urandom) : 14'(ADR_PEND + 14'($urandom_range(0, 3)));
            dma_io_wdata = $urandom;
            if (dma_io_wadr == ADR_CLAIM && $urandom_range(0, 1) == 1)
                dma_io_wdata = 32'(m_id);
            dma_io_radr_en = ($urandom_range(0, 2) == 0);
            dma_io_radr = ($urandom_range(0, 4) == 0) ? 14'($urandom)
                                                      : 14'(ADR_PEND + 14'($urandom_range(0, 3)));
            cyc();
        end
        dma_io_we = 1'b0;
        dma_io_radr_en = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
